// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris window sequencer.
package harris_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_FIRE,
      ST_WAIT,
      ST_EVAL,
      ST_EMIT,
      ST_DONE
   } state_t;

   localparam int WIN_N   = 4;
   localparam int WIN_PIX = 16;
   localparam int GRAD_W  = 16;
   localparam int SCORE_W = 64;

   function automatic int slot_lsb(input logic [3:0] k);
      return GRAD_W * int'(k);
   endfunction

endpackage

// File: rtl/harris_win_addr_gen.sv
// Window position (wx, wy) and slot counter k, plus the gradient RAM read address.
module harris_win_addr_gen #(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int ADDR_W  = 12,
   parameter int COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               step_k,
   input  logic               advance,
   output logic [COORD_W-1:0] wx,
   output logic [COORD_W-1:0] wy,
   output logic [3:0]         k,
   output logic [ADDR_W-1:0]  addr,
   output logic               last_k,
   output logic               last_win
);

   localparam logic [COORD_W-1:0] WX_LAST = COORD_W'(IMG_W - 4);
   localparam logic [COORD_W-1:0] WY_LAST = COORD_W'(IMG_H - 4);

   logic [COORD_W-1:0] wx_q, wx_d;
   logic [COORD_W-1:0] wy_q, wy_d;
   logic [3:0]         k_q, k_d;
   logic [ADDR_W-1:0]  row, col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wx_q <= '0;
         wy_q <= '0;
         k_q  <= '0;
      end else begin
         wx_q <= wx_d;
         wy_q <= wy_d;
         k_q  <= k_d;
      end
   end

   always_comb begin
      wx_d = wx_q;
      wy_d = wy_q;
      k_d  = k_q;
      if (clear) begin
         wx_d = '0;
         wy_d = '0;
         k_d  = '0;
      end else begin
         if (step_k) k_d = k_q + 4'd1;
         if (advance) begin
            k_d = '0;
            if (wx_q < WX_LAST) begin
               wx_d = wx_q + 1'b1;
            end else if (wy_q < WY_LAST) begin
               wx_d = '0;
               wy_d = wy_q + 1'b1;
            end
         end
      end
   end

   // Row/column widened to the address width so the product cannot wrap.
   always_comb begin
      row  = ADDR_W'(wy_q) + ADDR_W'(k_q[3:2]);
      col  = ADDR_W'(wx_q) + ADDR_W'(k_q[1:0]);
      addr = row * ADDR_W'(IMG_W) + col;
   end

   assign wx       = wx_q;
   assign wy       = wy_q;
   assign k        = k_q;
   assign last_k   = (k_q == 4'd15);
   assign last_win = (wx_q == WX_LAST) && (wy_q == WY_LAST);

endmodule

// File: rtl/harris_window_sequencer.sv
// Frame scan controller: fetches 4x4 gradient windows, scores them, emits corners.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | 16 RAM reads for the current window, slot k-1 captured each cycle
// DRAIN | capture last read (slot 15)
// FIRE  | win_valid pulse to the score unit
// WAIT  | score latency down-counter
// EVAL  | compare sampled R against thresh
// EMIT  | corner record offered until corner_ready
// DONE  | one-cycle done pulse
module harris_window_sequencer
   import harris_pkg::*;
#(
   parameter int IMG_W     = 64,
   parameter int IMG_H     = 64,
   parameter int ADDR_W    = 12,
   parameter int COORD_W   = 8,
   parameter int SCORE_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [63:0]        thresh,
   output logic               busy,
   output logic               done,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [15:0]        mem_gx,
   input  logic [15:0]        mem_gy,
   output logic [255:0]       win_gx,
   output logic [255:0]       win_gy,
   output logic               win_valid,
   input  logic [63:0]        score_r,
   output logic               corner_valid,
   input  logic               corner_ready,
   output logic [COORD_W-1:0] corner_x,
   output logic [COORD_W-1:0] corner_y,
   output logic [63:0]        corner_score,
   output logic [15:0]        corner_cnt
);

   localparam int LAT_W = (SCORE_LAT > 1) ? $clog2(SCORE_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(SCORE_LAT - 1);

   state_t               state_q, state_d;
   logic [255:0]         win_gx_q, win_gx_d;
   logic [255:0]         win_gy_q, win_gy_d;
   logic [SCORE_W-1:0]   corner_score_q, corner_score_d;
   logic [15:0]          corner_cnt_q, corner_cnt_d;
   logic [LAT_W-1:0]     lat_q, lat_d;

   logic                 clear, step_k, advance, do_adv;
   logic                 wr_en;
   logic [3:0]           wr_idx;
   logic [COORD_W-1:0]   wx, wy;
   logic [3:0]           k;
   logic                 last_k, last_win;

   harris_win_addr_gen #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .ADDR_W  (ADDR_W),
      .COORD_W (COORD_W)
   ) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .step_k   (step_k),
      .advance  (advance),
      .wx       (wx),
      .wy       (wy),
      .k        (k),
      .addr     (mem_addr),
      .last_k   (last_k),
      .last_win (last_win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         win_gx_q       <= '0;
         win_gy_q       <= '0;
         corner_score_q <= '0;
         corner_cnt_q   <= '0;
         lat_q          <= '0;
      end else begin
         state_q        <= state_d;
         win_gx_q       <= win_gx_d;
         win_gy_q       <= win_gy_d;
         corner_score_q <= corner_score_d;
         corner_cnt_q   <= corner_cnt_d;
         lat_q          <= lat_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      win_gx_d       = win_gx_q;
      win_gy_d       = win_gy_q;
      corner_score_d = corner_score_q;
      corner_cnt_d   = corner_cnt_q;
      lat_d          = lat_q;
      clear          = 1'b0;
      step_k         = 1'b0;
      advance        = 1'b0;
      do_adv         = 1'b0;
      wr_en          = 1'b0;
      wr_idx         = k - 4'd1;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               clear        = 1'b1;
               corner_cnt_d = '0;
               state_d      = ST_FETCH;
            end
         end
         ST_FETCH: begin
            step_k = 1'b1;
            wr_en  = (k != 4'd0);
            if (last_k) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            wr_en   = 1'b1;
            wr_idx  = 4'd15;
            state_d = ST_FIRE;
         end
         ST_FIRE: begin
            lat_d   = LAT_INIT;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               corner_score_d = score_r;
               state_d        = ST_EVAL;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_EVAL: begin
            if ($signed(corner_score_q) > $signed(thresh)) state_d = ST_EMIT;
            else do_adv = 1'b1;
         end
         ST_EMIT: begin
            if (corner_ready) begin
               if (corner_cnt_q != 16'hFFFF) corner_cnt_d = corner_cnt_q + 16'd1;
               do_adv = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (do_adv) begin
         if (last_win) begin
            state_d = ST_DONE;
         end else begin
            advance = 1'b1;
            state_d = ST_FETCH;
         end
      end

      if (wr_en) begin
         win_gx_d[slot_lsb(wr_idx) +: GRAD_W] = mem_gx;
         win_gy_d[slot_lsb(wr_idx) +: GRAD_W] = mem_gy;
      end

      // Abort freezes counters and the corner count; only the state returns to IDLE.
      if (abort && state_q != ST_IDLE) begin
         state_d      = ST_IDLE;
         step_k       = 1'b0;
         advance      = 1'b0;
         corner_cnt_d = corner_cnt_q;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign mem_rd_en    = (state_q == ST_FETCH);
   assign win_valid    = (state_q == ST_FIRE);
   assign corner_valid = (state_q == ST_EMIT);
   assign win_gx       = win_gx_q;
   assign win_gy       = win_gy_q;
   assign corner_x     = wx;
   assign corner_y     = wy;
   assign corner_score = corner_score_q;
   assign corner_cnt   = corner_cnt_q;

endmodule
